cfg_byte_loader: RTL

- Upstream command front-end for config_reg.
- Accepts a byte stream over a valid/ready handshake and decodes 3-byte write frames and 1-byte read frames.
- Writes: drives config_reg's write, address and data_in ports.
- Reads: samples config_reg's data_out and returns it as a 2-byte response stream.

---
 rtl/cfg_byte_loader_pkg.sv | 24 ++
 rtl/cfg_byte_loader_if.sv | 21 ++
 rtl/cfg_byte_loader_timeout.sv | 27 ++
 rtl/cfg_byte_loader.sv | 137 +++++++++++++
 4 files changed

// File: rtl/cfg_byte_loader_pkg.sv
// rtl/cfg_byte_loader_pkg.sv - shared constants, state encoding and command decode for the config byte loader
package cfg_loader_pkg;

  localparam int CMD_RW_BIT   = 7;
  localparam int CMD_RSVD_MSB = 6;
  localparam int CMD_RSVD_LSB = 3;
  localparam int CFG_ADDR_W   = 3;
  localparam int CFG_DATA_W   = 16;

  typedef logic [2:0] state_t;

  localparam state_t CMD = 3'd0;
  localparam state_t DHI = 3'd1;
  localparam state_t DLO = 3'd2;
  localparam state_t WR  = 3'd3;
  localparam state_t RDW = 3'd4;
  localparam state_t RHI = 3'd5;
  localparam state_t RLO = 3'd6;

  function automatic logic cmd_rsvd_bad(input logic [7:0] b);
    return |b[CMD_RSVD_MSB:CMD_RSVD_LSB];
  endfunction

endpackage

// File: rtl/cfg_byte_loader_if.sv
// rtl/cfg_byte_loader_if.sv - command byte stream in and response byte stream out
interface cfg_byte_loader_if;

  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

endinterface

// File: rtl/cfg_byte_loader_timeout.sv
// rtl/cfg_byte_loader_timeout.sv - loadable down-counter; expired fires on an enabled cycle at zero
module cfg_loader_timeout #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign expired = en && !load && (count == '0);

endmodule

// File: rtl/cfg_byte_loader.sv
// rtl/cfg_byte_loader.sv - decodes byte-stream write/read frames into config_reg accesses
module cfg_byte_loader
  import cfg_loader_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset,
  cfg_byte_loader_if.slave      strm,
  output logic                  cfg_write,
  output logic [CFG_ADDR_W-1:0] cfg_address,
  output logic [CFG_DATA_W-1:0] cfg_data_in,
  input  logic [CFG_DATA_W-1:0] cfg_data_out,
  output logic [7:0]            err_count
);

  state_t     state;
  logic [7:0] data_hi;
  logic [7:0] resp_lo;
  logic [7:0] out_data_q;
  logic       out_valid_q;

  logic       in_xfer;
  logic       out_xfer;
  logic       rsvd_bad;
  logic       is_read;
  logic       cmd_ok;
  logic       tmr_load;
  logic [7:0] tmr_val;
  logic       tmr_en;
  logic       tmr_exp;
  logic       abort;
  logic       rd_done;
  logic       err_inc;

  assign strm.in_ready  = (state == CMD) || (state == DHI) || (state == DLO);
  assign strm.out_valid = out_valid_q;
  assign strm.out_data  = out_data_q;

  assign in_xfer  = strm.in_valid && strm.in_ready;
  assign out_xfer = out_valid_q && strm.out_ready;
  assign rsvd_bad = cmd_rsvd_bad(strm.in_data);
  assign is_read  = strm.in_data[CMD_RW_BIT];
  assign cmd_ok   = (state == CMD) && in_xfer && !rsvd_bad;

  // One counter serves both waits: RD_LAT for the read pipe, TIMEOUT-1 for inter-byte idle.
  assign tmr_load = cmd_ok || ((state == DHI) && in_xfer);
  assign tmr_val  = (cmd_ok && is_read) ? 8'(RD_LAT) : 8'(TIMEOUT - 1);
  assign tmr_en   = (state == RDW) || (((state == DHI) || (state == DLO)) && !in_xfer);

  cfg_loader_timeout #(.W(8)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .expired  (tmr_exp)
  );

  assign abort   = tmr_exp && ((state == DHI) || (state == DLO));
  assign rd_done = tmr_exp && (state == RDW);
  assign err_inc = ((state == CMD) && in_xfer && rsvd_bad) || abort;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= CMD;
      data_hi     <= '0;
      resp_lo     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      cfg_write   <= 1'b0;
      cfg_address <= '0;
      cfg_data_in <= '0;
      err_count   <= '0;
    end else begin
      cfg_write <= (state == DLO) && in_xfer;

      case (state)
        CMD: begin
          if (cmd_ok) begin
            cfg_address <= strm.in_data[CFG_ADDR_W-1:0];
            state       <= is_read ? RDW : DHI;
          end
        end
        DHI: begin
          if (abort) begin
            state <= CMD;
          end else if (in_xfer) begin
            data_hi <= strm.in_data;
            state   <= DLO;
          end
        end
        DLO: begin
          if (abort) begin
            state <= CMD;
          end else if (in_xfer) begin
            // High byte is held aside so an aborted frame never disturbs cfg_data_in.
            cfg_data_in <= {data_hi, strm.in_data};
            state       <= WR;
          end
        end
        WR: begin
          state <= CMD;
        end
        RDW: begin
          if (rd_done) begin
            resp_lo     <= cfg_data_out[7:0];
            out_data_q  <= cfg_data_out[15:8];
            out_valid_q <= 1'b1;
            state       <= RHI;
          end
        end
        RHI: begin
          if (out_xfer) begin
            out_data_q <= resp_lo;
            state      <= RLO;
          end
        end
        RLO: begin
          if (out_xfer) begin
            out_valid_q <= 1'b0;
            state       <= CMD;
          end
        end
        default: begin
          state <= CMD;
        end
      endcase

      if (err_inc && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end
    end
  end

endmodule
